// File: rtl/data_checker.sv
// Receive-side checker for the 512-bit test-packet stream: verifies counter, packet number,
// inverse fields and TLAST framing. Optional macro RANDOM_BACKPRESSURE_EN adds LFSR-driven TREADY stalls.
module data_checker #(
  parameter int          ERR_W     = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic [7:0]       packet_length,
  input  logic [511:0]     AXIS_RX_TDATA,
  input  logic [63:0]      AXIS_RX_TKEEP,
  input  logic             AXIS_RX_TVALID,
  input  logic             AXIS_RX_TLAST,
  output logic             AXIS_RX_TREADY,
  output logic [63:0]      beats_rcvd,
  output logic [63:0]      packets_rcvd,
  output logic [ERR_W-1:0] error_count,
  output logic [3:0]       error_flags,
  output logic [63:0]      first_err_beat
);

  logic [63:0] exp_ctr;
  logic [63:0] exp_pkt;
  logic [7:0]  cycle_index;
  logic [7:0]  latched_pl;
  logic        accept;
  logic        last_exp;
  logic [3:0]  err_vec;

  // TKEEP and the free-form middle of the beat carry nothing the checker inspects.
  logic unused_inputs;
  assign unused_inputs = (^AXIS_RX_TKEEP) ^ (^AXIS_RX_TDATA[383:128]);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // A clear in the same cycle as a beat discards the beat entirely.
  assign accept   = AXIS_RX_TVALID & AXIS_RX_TREADY & ~clear;
  assign last_exp = (cycle_index == latched_pl);

  always_comb begin
    err_vec    = 4'b0000;
    err_vec[0] = (AXIS_RX_TDATA[63:0]   != exp_ctr);
    err_vec[1] = (AXIS_RX_TDATA[127:64] != exp_pkt);
    err_vec[2] = (AXIS_RX_TDATA[447:384] != ~AXIS_RX_TDATA[127:64]) ||
                 (AXIS_RX_TDATA[511:448] != ~AXIS_RX_TDATA[63:0]);
    err_vec[3] = (AXIS_RX_TLAST != last_exp);
  end

  // Stage p0: checks above resolve into statistics on the accepting edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      exp_ctr        <= '0;
      exp_pkt        <= '0;
      cycle_index    <= 8'd1;
      latched_pl     <= 8'd4;
      beats_rcvd     <= '0;
      packets_rcvd   <= '0;
      error_count    <= '0;
      error_flags    <= '0;
      first_err_beat <= '0;
    end else if (clear) begin
      exp_ctr        <= '0;
      exp_pkt        <= '0;
      cycle_index    <= 8'd1;
      latched_pl     <= (packet_length == 8'd0) ? 8'd4 : packet_length;
      beats_rcvd     <= '0;
      packets_rcvd   <= '0;
      error_count    <= '0;
      error_flags    <= '0;
      first_err_beat <= '0;
    end else if (accept) begin
      exp_ctr    <= exp_ctr + 64'd1;
      beats_rcvd <= beats_rcvd + 64'd1;
      if (AXIS_RX_TLAST)
        packets_rcvd <= packets_rcvd + 64'd1;
      // Framing follows the expected length, not the received TLAST.
      if (last_exp) begin
        cycle_index <= 8'd1;
        exp_pkt     <= exp_pkt + 64'd1;
      end else begin
        cycle_index <= cycle_index + 8'd1;
      end
      if (|err_vec) begin
        error_flags <= error_flags | err_vec;
        error_count <= sat_inc(error_count);
        if (error_flags == 4'b0000)
          first_err_beat <= beats_rcvd;
      end
    end
  end

`ifdef RANDOM_BACKPRESSURE_EN
  logic [31:0] lfsr;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr           <= LFSR_SEED;
      AXIS_RX_TREADY <= 1'b0;
    end else begin
      lfsr           <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
      AXIS_RX_TREADY <= (lfsr[1:0] != 2'b00);
    end
  end
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;

  always_ff @(posedge clk) begin
    if (!resetn)
      AXIS_RX_TREADY <= 1'b0;
    else
      AXIS_RX_TREADY <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_data_checker.sv
// Directed-vector bench for data_checker (ERR_W=4 so saturation is reachable).
module tb_data_checker;

  logic         clk = 1'b0;
  logic         resetn;
  logic         clear;
  logic [7:0]   packet_length;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tvalid;
  logic         tlast;
  logic         tready;
  logic [63:0]  beats_rcvd;
  logic [63:0]  packets_rcvd;
  logic [3:0]   error_count;
  logic [3:0]   error_flags;
  logic [63:0]  first_err_beat;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_checker #(.ERR_W(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .clear          (clear),
    .packet_length  (packet_length),
    .AXIS_RX_TDATA  (tdata),
    .AXIS_RX_TKEEP  (tkeep),
    .AXIS_RX_TVALID (tvalid),
    .AXIS_RX_TLAST  (tlast),
    .AXIS_RX_TREADY (tready),
    .beats_rcvd     (beats_rcvd),
    .packets_rcvd   (packets_rcvd),
    .error_count    (error_count),
    .error_flags    (error_flags),
    .first_err_beat (first_err_beat)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk(input logic [63:0] ctr, input logic [63:0] pkt);
    logic [511:0] d;
    d[63:0]    = ctr;
    d[127:64]  = pkt;
    d[383:128] = {4{ctr ^ 64'h5A5A_0F0F_3C3C_9696}};
    d[447:384] = ~pkt;
    d[511:448] = ~ctr;
    return d;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic send(input logic [511:0] d, input logic last);
    int waits;
    waits  = 0;
    tdata  = d;
    tlast  = last;
    tvalid = 1'b1;
    while (!tready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!tready) begin
      check("tready_timeout", 64'd0, 64'd1);
      tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic do_clear(input logic [7:0] pl);
    clear         = 1'b1;
    packet_length = pl;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    int lows;
    resetn = 1'b0; clear = 1'b0; packet_length = 8'd0;
    tdata = '0; tkeep = '1; tvalid = 1'b0; tlast = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_tready", {63'd0, tready}, 64'd0);
    check("rst_beats", beats_rcvd, 64'd0);
    check("rst_pkts", packets_rcvd, 64'd0);
    check("rst_ecnt", {60'd0, error_count}, 64'd0);
    check("rst_flags", {60'd0, error_flags}, 64'd0);
    check("rst_first", first_err_beat, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
`ifndef RANDOM_BACKPRESSURE_EN
    check("tready_after_rst", {63'd0, tready}, 64'd1);
`endif

    // Clean run, length 3; packet_length changes after clear must not matter.
    do_clear(8'd3);
    packet_length = 8'd7;
    for (int i = 0; i < 12; i++) begin
      send(mk(i, i / 3), (i % 3) == 2);
      if (i == 0) check("latency_beat1", beats_rcvd, 64'd1);
    end
    check("clean_beats", beats_rcvd, 64'd12);
    check("clean_pkts", packets_rcvd, 64'd4);
    check("clean_ecnt", {60'd0, error_count}, 64'd0);
    check("clean_flags", {60'd0, error_flags}, 64'd0);

    // Counter corruption on beat 5, length 4.
    do_clear(8'd4);
    for (int i = 0; i < 8; i++) begin
      d = mk(i, i / 4);
      if (i == 5) d[63:0] = 64'hFF;
      send(d, (i % 4) == 3);
    end
    check("ctr_flags", {60'd0, error_flags}, 64'b0101);
    check("ctr_ecnt", {60'd0, error_count}, 64'd1);
    check("ctr_first", first_err_beat, 64'd5);
    check("ctr_beats", beats_rcvd, 64'd8);

    // Framing: early TLAST on beat 0, missing TLAST on beat 3, length 2.
    do_clear(8'd2);
    send(mk(0, 0), 1'b1);
    send(mk(1, 0), 1'b1);
    send(mk(2, 1), 1'b0);
    send(mk(3, 1), 1'b0);
    check("frm_flags", {60'd0, error_flags}, 64'b1000);
    check("frm_ecnt", {60'd0, error_count}, 64'd2);
    check("frm_first", first_err_beat, 64'd0);
    check("frm_pkts", packets_rcvd, 64'd2);

    // packet_length 0 behaves as 4.
    do_clear(8'd0);
    for (int i = 0; i < 8; i++) send(mk(i, i / 4), (i % 4) == 3);
    check("pl0_flags", {60'd0, error_flags}, 64'd0);
    check("pl0_pkts", packets_rcvd, 64'd2);
    do_clear(8'd0);
    send(mk(0, 0), 1'b0);
    send(mk(1, 0), 1'b1);
    check("pl0_early_flags", {60'd0, error_flags}, 64'b1000);
    check("pl0_early_first", first_err_beat, 64'd1);

    // Clear colliding with a valid beat.
    do_clear(8'd3);
    send(mk(0, 0), 1'b0);
    send(mk(1, 0), 1'b0);
    clear = 1'b1; packet_length = 8'd3;
    tdata = mk(2, 0); tlast = 1'b0; tvalid = 1'b1;
    @(negedge clk);
    clear = 1'b0; tvalid = 1'b0;
    check("coll_beats", beats_rcvd, 64'd0);
    check("coll_flags", {60'd0, error_flags}, 64'd0);
    send(mk(0, 0), 1'b0);
    check("coll_next_beats", beats_rcvd, 64'd1);
    check("coll_next_flags", {60'd0, error_flags}, 64'd0);

    // Error count saturation with a 4-bit counter.
    do_clear(8'd4);
    for (int i = 0; i < 20; i++) begin
      d = mk(i, i / 4);
      d[63:0] = d[63:0] ^ 64'd1;
      send(d, (i % 4) == 3);
    end
    check("sat_ecnt", {60'd0, error_count}, 64'd15);
    check("sat_flags", {60'd0, error_flags}, 64'b0101);
    check("sat_beats", beats_rcvd, 64'd20);

    // Reset mid-packet: expectations restart, length returns to 4.
    do_clear(8'd3);
    send(mk(0, 0), 1'b0);
    send(mk(1, 0), 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_tready", {63'd0, tready}, 64'd0);
    check("midrst_beats", beats_rcvd, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(mk(i, 0), i == 3);
    check("midrst_flags", {60'd0, error_flags}, 64'd0);
    check("midrst_beats_after", beats_rcvd, 64'd4);
    check("midrst_pkts", packets_rcvd, 64'd1);

`ifdef RANDOM_BACKPRESSURE_EN
    do_clear(8'd4);
    for (int i = 0; i < 1000; i++) send(mk(i, i / 4), (i % 4) == 3);
    check("bp_beats", beats_rcvd, 64'd1000);
    check("bp_ecnt", {60'd0, error_count}, 64'd0);
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!tready) lows++;
      @(negedge clk);
    end
    check("bp_stall_ratio", {63'd0, (lows >= 150 && lows <= 350)}, 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_checker.md
Name: data_checker

Overview:
Receive-side checker that sits directly downstream of the packet data generator, or at the far end of the loopback path. It consumes the 512-bit AXI-Stream of test packets and checks every beat against the expected counter and packet-number pattern. It also checks packet framing (TLAST position) and maintains counts and sticky error status for software readout. It always accepts data, except when the optional back-pressure feature is compiled in.

Parameters:
ERR_W, 32, width of error_count (saturating)
LFSR_SEED, 32'hACE1_1234, non-zero seed for the optional back-pressure LFSR

Ports:
clk  input  1  clock
resetn  input  1  reset, synchronous, active-low
clear  input  1  one-cycle pulse: zero all statistics, reset expectations, latch packet_length
packet_length  input  8  beats per packet; 0 means 4
AXIS_RX_TDATA  input  512  packet data
AXIS_RX_TKEEP  input  64  ignored (generator drives all ones)
AXIS_RX_TVALID  input  1  beat valid
AXIS_RX_TLAST  input  1  last beat of packet
AXIS_RX_TREADY  output  1  registered ready
beats_rcvd  output  64  accepted beats since clear
packets_rcvd  output  64  accepted beats with TLAST=1 since clear
error_count  output  ERR_W  beats containing at least one error; saturates at all-ones
error_flags  output  4  sticky: [0] counter, [1] packet_num, [2] inverse field, [3] TLAST position
first_err_beat  output  64  beats_rcvd value of the first erroneous beat; valid when error_flags!=0

Behaviour:
- Reset (resetn=0 at a clk edge) zeroes all outputs and internal state, including AXIS_RX_TREADY. It also sets latched_pl=4 and cycle_index=1. AXIS_RX_TREADY rises on the first edge after reset is released.
- Accept = AXIS_RX_TVALID & AXIS_RX_TREADY. All checks and updates happen only on accepted beats. Statistics update on the clock edge at the end of the accepting cycle (1-cycle latency).
- Internal expectations: exp_ctr (64 bits, starts at 0), exp_pkt (64 bits, starts at 0), cycle_index (8 bits, counts 1..latched_pl).
- Per accepted beat, the checks are:
  - [0] TDATA[63:0] != exp_ctr
  - [1] TDATA[127:64] != exp_pkt
  - [2] TDATA[447:384] != ~TDATA[127:64], OR TDATA[511:448] != ~TDATA[63:0]
  - [3] TLAST != (cycle_index == latched_pl)
  - TDATA[383:128] is not checked.
- Effect of errors on an accepted beat:
  - Any failed check ORs the failing bits into error_flags.
  - error_count increments by 1 per erroneous beat, not per failed check, and holds at all-ones once saturated.
  - If error_flags was 0 before the beat, first_err_beat <= beats_rcvd (the pre-increment value).
- Advance rules on every accepted beat:
  - exp_ctr <= exp_ctr + 1; beats_rcvd <= beats_rcvd + 1.
  - cycle_index wraps to 1 when cycle_index == latched_pl, otherwise increments. Framing follows the expected length, not the received TLAST.
  - exp_pkt increments when cycle_index == latched_pl (expected end of packet).
  - packets_rcvd increments when the received TLAST=1.
- Wrap: all 64-bit counters wrap modulo 2^64. This is expected behaviour, not an error.
- clear: zeroes the statistics, error_flags, first_err_beat, exp_ctr and exp_pkt. It sets cycle_index=1 and latched_pl = (packet_length==0) ? 4 : packet_length.
- clear and an accepted beat in the same cycle: clear wins and the beat is discarded uncounted.
- clear does not affect TREADY.
- packet_length is sampled only at clear.
- Reset mid-packet: everything returns to reset values and the next accepted beat is checked as beat 0 of packet 0. The upstream generator must be restarted by the same reset or by a later start/clear.

Optional Feature:
Macro RANDOM_BACKPRESSURE_EN.
- Defined: a 32-bit Galois LFSR (taps 32,22,2,1; seeded with LFSR_SEED on reset) advances every cycle. AXIS_RX_TREADY <= ~(lfsr[1:0]==2'b00), giving roughly 25% stall cycles. Data checking is unchanged. TREADY may drop while TVALID=1, and the upstream block must hold data.
- Not defined: AXIS_RX_TREADY is constant 1 from the first cycle after reset.

Test Plan:
- Clean run: clear with packet_length=3, then 4 packets (12 beats) of correct pattern -> beats_rcvd=12, packets_rcvd=4, error_count=0, error_flags=0.
- Counter corruption: packet_length=4, beat 5 has TDATA[63:0]=0xFF -> error_flags=4'b0101 (counter and inverse both fail), error_count=1, first_err_beat=5; later beats clean.
- Framing error: packet_length=2, TLAST asserted on beat 0 -> flags[3] set; also TLAST missing on beat 3 -> error_count=2, packets_rcvd reflects received TLASTs only.
- packet_length=0: clear, then TLAST every 4th beat for 8 beats -> no errors, packets_rcvd=2; TLAST on the 2nd beat -> flags[3].
- Clear collision: clear pulsed in the same cycle as an accepted beat -> all stats 0, and the next beat must carry counter 0.
- Back-pressure (macro defined): 1000 clean beats at TVALID=1 -> beats_rcvd=1000, error_count=0, TREADY low on roughly 20-30% of cycles. Also error_count saturation with ERR_W=4: 20 bad beats -> error_count=15.
